// File: rtl/keypad_uart_tx.sv
`timescale 1ns/1ps
// keypad_uart_tx: matrix keypad scanner with press/release debounce, key FIFO
// and an 8N1 UART sender emitting PREFIX + ASCII key per accepted key.
// Optional build macro: KPU_CRLF_EN appends 0x0D 0x0A to every message.
module keypad_uart_tx #(
   parameter int         CLK_HZ         = 27000000,
   parameter int         BAUD           = 9600,
   parameter int         ROWS           = 4,
   parameter int         COLS           = 4,
   parameter int         SCAN_DIV       = 27000,
   parameter int         DEBOUNCE_SCANS = 4,
   parameter int         FIFO_DEPTH     = 8,
   parameter logic [7:0] PREFIX         = 8'h32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ROWS-1:0]               row_in,
   output logic [COLS-1:0]               col_out,
   output logic                          key_valid,
   output logic [3:0]                    key_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          tx_busy,
   output logic                          uart_tx
);

   localparam int BAUD_DIV = CLK_HZ / BAUD;
   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(BAUD_DIV);
`ifdef KPU_CRLF_EN
   localparam int MSG_BYTES = 4;
`else
   localparam int MSG_BYTES = 2;
`endif
   localparam logic [TW-1:0] TMAX      = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_SCANS - 1);
   localparam logic [1:0]    COL_LAST  = 2'(COLS - 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [1:0]    BYTE_LAST = 2'(MSG_BYTES - 1);

   typedef enum logic [1:0] {S_SCAN, S_PRESS_DB, S_HELD, S_RELEASE_DB} scan_state_t;
   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

   function automatic logic [7:0] key_ascii(input logic [3:0] k);
      case (k)
         4'd0:  key_ascii = "1";  4'd1:  key_ascii = "2";
         4'd2:  key_ascii = "3";  4'd3:  key_ascii = "A";
         4'd4:  key_ascii = "4";  4'd5:  key_ascii = "5";
         4'd6:  key_ascii = "6";  4'd7:  key_ascii = "B";
         4'd8:  key_ascii = "7";  4'd9:  key_ascii = "8";
         4'd10: key_ascii = "9";  4'd11: key_ascii = "C";
         4'd12: key_ascii = "*";  4'd13: key_ascii = "0";
         4'd14: key_ascii = "#";  default: key_ascii = "D";
      endcase
   endfunction

   function automatic logic [7:0] msg_byte(input logic [1:0] idx, input logic [3:0] k);
      case (idx)
         2'd0:    msg_byte = PREFIX;
         2'd1:    msg_byte = key_ascii(k);
         2'd2:    msg_byte = 8'h0D;
         default: msg_byte = 8'h0A;
      endcase
   endfunction

   // ---------------- row synchroniser ----------------
   logic [ROWS-1:0] row_meta_q, row_sync_q;

   // Two-flop synchroniser for the asynchronous keypad rows (idle high).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta_q <= '1;
         row_sync_q <= '1;
      end else begin
         row_meta_q <= row_in;
         row_sync_q <= row_meta_q;
      end
   end

   // ---------------- scanner ----------------
   scan_state_t     scan_q, scan_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [1:0]      col_q, col_d, row_q, row_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic [COLS-1:0] col_out_q, col_out_d;
   logic            key_valid_q, key_valid_d;
   logic [3:0]      key_code_q, key_code_d;
   logic            push;
   logic            sample, any_low, row_low;
   logic [1:0]      low_row, next_col;

   assign sample   = (tmr_q == TMAX);
   assign row_low  = ~row_sync_q[row_q];
   assign next_col = (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;

   // Find the lowest-numbered row currently pulled low.
   always_comb begin
      any_low = 1'b0;
      low_row = 2'd0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!row_sync_q[i]) begin
            any_low = 1'b1;
            low_row = 2'(i);
         end
      end
   end

   // Scanner next-state: column walk, press debounce, hold, release debounce.
   always_comb begin
      scan_d      = scan_q;
      tmr_d       = sample ? '0 : tmr_q + 1'b1;
      col_d       = col_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      push        = 1'b0;
      unique case (scan_q)
         S_SCAN: if (sample) begin
            if (any_low) begin
               row_d = low_row;
               cnt_d = DW'(1);
               if (DEBOUNCE_SCANS == 1) begin
                  scan_d      = S_HELD;
                  key_valid_d = 1'b1;
                  key_code_d  = {low_row, col_q};
                  push        = 1'b1;
               end else begin
                  scan_d = S_PRESS_DB;
               end
            end else begin
               col_d = next_col;
            end
         end
         S_PRESS_DB: if (sample) begin
            if (row_low) begin
               if (cnt_q == DB_LAST) begin
                  scan_d      = S_HELD;
                  key_valid_d = 1'b1;
                  key_code_d  = {row_q, col_q};
                  push        = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               scan_d = S_SCAN;
               col_d  = next_col;
            end
         end
         S_HELD: if (sample && !row_low) begin
            if (DEBOUNCE_SCANS == 1) begin
               scan_d = S_SCAN;
               col_d  = next_col;
            end else begin
               scan_d = S_RELEASE_DB;
               cnt_d  = DW'(1);
            end
         end
         S_RELEASE_DB: if (sample) begin
            if (row_low) begin
               scan_d = S_HELD;
            end else if (cnt_q == DB_LAST) begin
               scan_d = S_SCAN;
               col_d  = next_col;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: scan_d = S_SCAN;
      endcase
      col_out_d = ~(COLS'(1) << col_d);
   end

   // Scanner registers. Reset parks on the last column at its sample point with
   // no column driven, so the first real visit (column 0) gets a full period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_q      <= S_SCAN;
         tmr_q       <= TMAX;
         col_q       <= COL_LAST;
         row_q       <= 2'd0;
         cnt_q       <= '0;
         col_out_q   <= '1;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
      end else begin
         scan_q      <= scan_d;
         tmr_q       <= tmr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         col_out_q   <= col_out_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   // ---------------- key FIFO (first-word fall-through) ----------------
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          pop, do_push, full;
   logic [3:0]    head;

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign do_push = push && (!full || pop);
   assign head    = mem_q[rd_q];

   // FIFO pointer/count update; a push into a full FIFO without a pop is dropped.
   always_comb begin
      wr_d       = do_push ? wr_q + 1'b1 : wr_q;
      rd_d       = pop ? rd_q + 1'b1 : rd_q;
      count_d    = count_q;
      if (do_push && !pop) count_d = count_q + 1'b1;
      if (!do_push && pop) count_d = count_q - 1'b1;
      overflow_d = overflow_q | (push & ~do_push);
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= key_code_d;
   end

   // FIFO control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------- UART transmitter ----------------
   uart_state_t   ust_q, ust_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [3:0]    code_q, code_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d, busy_q, busy_d;
   logic          baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   // UART next-state; a new message starts straight out of the last stop bit
   // when keys are waiting, so consecutive messages have no idle gap.
   always_comb begin
      ust_d   = ust_q;
      baud_d  = baud_end ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      byte_d  = byte_q;
      code_d  = code_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      unique case (ust_q)
         U_IDLE: begin
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               code_d  = head;
               byte_d  = 2'd0;
               shift_d = PREFIX;
               ust_d   = U_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         U_START: if (baud_end) begin
            bit_d = 3'd0;
            ust_d = U_DATA;
            tx_d  = shift_q[0];
         end
         U_DATA: if (baud_end) begin
            if (bit_q == 3'd7) begin
               ust_d = U_STOP;
               tx_d  = 1'b1;
            end else begin
               bit_d   = bit_q + 3'd1;
               shift_d = shift_q >> 1;
               tx_d    = shift_q[1];
            end
         end
         U_STOP: if (baud_end) begin
            if (byte_q != BYTE_LAST) begin
               byte_d  = byte_q + 2'd1;
               shift_d = msg_byte(byte_q + 2'd1, code_q);
               ust_d   = U_START;
               tx_d    = 1'b0;
            end else if (count_q != '0) begin
               pop     = 1'b1;
               code_d  = head;
               byte_d  = 2'd0;
               shift_d = PREFIX;
               ust_d   = U_START;
               tx_d    = 1'b0;
            end else begin
               ust_d  = U_IDLE;
               busy_d = 1'b0;
            end
         end
         default: ust_d = U_IDLE;
      endcase
   end

   // UART registers; reset forces the line idle-high immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ust_q   <= U_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         byte_q  <= 2'd0;
         code_q  <= 4'd0;
         shift_q <= 8'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         ust_q   <= ust_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         code_q  <= code_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign col_out    = col_out_q;
   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign tx_busy    = busy_q;
   assign uart_tx    = tx_q;

endmodule

// File: tb/tb_keypad_uart_tx.sv
`timescale 1ns/1ps
// tb_keypad_uart_tx: keypad model driving the scanner, UART line receiver and
// a byte-stream reference built from the key map; randomized key sequences.
module tb_keypad_uart_tx;

   localparam int SCAN_DIV = 4;
   localparam int DB       = 2;
   localparam int BIT_CYC  = 16;
   localparam int CLK_NS   = 10;
`ifdef KPU_CRLF_EN
   localparam int MSG_BYTES = 4;
`else
   localparam int MSG_BYTES = 2;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_in, col_out, key_code;
   logic       key_valid, overflow, tx_busy, uart_tx;
   logic [2:0] fifo_count;

   keypad_uart_tx #(
      .CLK_HZ(160), .BAUD(10), .ROWS(4), .COLS(4), .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(4), .PREFIX(8'h32)
   ) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
      .key_valid(key_valid), .key_code(key_code), .fifo_count(fifo_count),
      .overflow(overflow), .tx_busy(tx_busy), .uart_tx(uart_tx)
   );

   always #(CLK_NS/2) clk = ~clk;

   // keypad: pressed key shorts its row to its column while that column is driven low
   logic key_down = 1'b0;
   int   key_r = 0, key_c = 0;
   always_comb begin
      row_in = 4'hF;
      if (key_down && col_out[key_c] == 1'b0) row_in[key_r] = 1'b0;
   end

   int n_vec = 0, n_bad = 0;
   int kv_cycles = 0, fifo_peak = 0;
   logic [7:0] rx_bytes[$];
   time        rx_start[$];
   logic [7:0] exp_bytes[$];
   string      key_map = "123A456B789C*0#D";

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // key_valid activity and FIFO occupancy peak
   always @(negedge clk) begin
      if (key_valid === 1'b1) kv_cycles++;
      if (int'(fifo_count) > fifo_peak) fifo_peak = int'(fifo_count);
   end

   // UART receiver: mid-bit sampling, records each byte and its start time
   initial begin : uart_mon
      logic       prev;
      logic [7:0] b;
      time        t0;
      prev = 1'b1;
      b = 8'd0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && prev && uart_tx === 1'b0) begin
            t0 = $time;
            repeat (BIT_CYC/2) @(negedge clk);
            if (uart_tx === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (BIT_CYC) @(negedge clk);
                  b[i] = uart_tx;
               end
               repeat (BIT_CYC) @(negedge clk);
               rx_bytes.push_back(b);
               rx_start.push_back(t0);
            end
         end
         prev = uart_tx;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_msg(input int idx);
      exp_bytes.push_back(8'h32);
      exp_bytes.push_back(key_map[idx]);
`ifdef KPU_CRLF_EN
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
`endif
   endtask

   task automatic press(input int idx);
      int kv0, t;
      key_r = idx / 4;
      key_c = idx % 4;
      key_down = 1'b1;
      kv0 = kv_cycles;
      t = 0;
      while (kv_cycles == kv0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_eq("accept_seen", 32'(t < 200), 1);
      @(negedge clk);
      check_eq($sformatf("key_code_k%0d", idx), 32'(key_code), idx);
   endtask

   task automatic release_key();
      key_down = 1'b0;
      cycles(DB*SCAN_DIV + 3*SCAN_DIV);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((tx_busy || fifo_count != 3'd0) && t < 6000) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain_done", 32'(t < 6000), 1);
      cycles(4);
   endtask

   task automatic compare_rx(input string tag);
      check_eq({tag, "_nbytes"}, rx_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++)
         check_eq($sformatf("%s_b%0d", tag, i), 32'(rx_bytes[i]), 32'(exp_bytes[i]));
      rx_bytes.delete();
      rx_start.delete();
      exp_bytes.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_col_out"},   32'(col_out), 32'hF);
      check_eq({tag, "_uart_tx"},   32'(uart_tx), 1);
      check_eq({tag, "_key_valid"}, 32'(key_valid), 0);
      check_eq({tag, "_key_code"},  32'(key_code), 0);
      check_eq({tag, "_fifo_cnt"},  32'(fifo_count), 0);
      check_eq({tag, "_overflow"},  32'(overflow), 0);
      check_eq({tag, "_tx_busy"},   32'(tx_busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kv0, k, n, t;
      logic [3:0] one, exp_col;
      one = 4'b0001;
      rst = 1'b0;
      cycles(3);
      check_reset_outputs("rst");
      rst = 1'b1;
      cycles(2);

      // 1: key 6 (row 1, column 2)
      kv0 = kv_cycles;
      press(6);
      push_msg(6);
      release_key();
      drain();
      check_eq("s1_kv_pulses", kv_cycles - kv0, 1);
      if (rx_start.size() >= 2)
         check_eq("s1_frame_cycles", 32'((rx_start[1] - rx_start[0]) / CLK_NS), 160);
      else
         check_eq("s1_frames_seen", rx_start.size(), 2);
      compare_rx("s1");

      // 2: single-sample bounce on row 2 while column 1 is driven
      kv0 = kv_cycles;
      fifo_peak = 0;
      t = 0;
      while (col_out == 4'b1101 && t < 40) begin @(negedge clk); t++; end
      t = 0;
      while (col_out != 4'b1101 && t < 40) begin @(negedge clk); t++; end
      key_r = 2; key_c = 1;
      key_down = 1'b1;
      cycles(SCAN_DIV);
      key_down = 1'b0;
      t = 0;
      while (col_out == 4'b1101 && t < 40) begin @(negedge clk); t++; end
      check_eq("s2_next_col", 32'(col_out), 32'h0B);
      cycles(30);
      check_eq("s2_kv_pulses", kv_cycles - kv0, 0);
      check_eq("s2_fifo_peak", fifo_peak, 0);

      // 3: key 13 then key 0 during the first message -> back-to-back messages
      fifo_peak = 0;
      press(13); push_msg(13); release_key();
      press(0);  push_msg(0);  release_key();
      drain();
      check_eq("s3_fifo_peak", fifo_peak, 1);
      if (rx_start.size() > MSG_BYTES)
         check_eq("s3_msg_gap", 32'((rx_start[MSG_BYTES] - rx_start[0]) / CLK_NS), MSG_BYTES*160);
      else
         check_eq("s3_frames_seen", rx_start.size(), 2*MSG_BYTES);
      compare_rx("s3");

      // 4: six fast random presses -> FIFO saturates, sixth key dropped
      fifo_peak = 0;
      kv0 = kv_cycles;
      for (int i = 0; i < 6; i++) begin
         k = int'($urandom_range(15, 0));
         press(k);
         if (i < 5) push_msg(k);
         release_key();
      end
      check_eq("s4_kv_pulses", kv_cycles - kv0, 6);
      check_eq("s4_overflow", 32'(overflow), 1);
      drain();
      check_eq("s4_fifo_peak", fifo_peak, 4);
      check_eq("s4_overflow_sticky", 32'(overflow), 1);
      compare_rx("s4");

      // 5: asynchronous reset in the middle of a data bit
      k = int'($urandom_range(15, 0));
      press(k);
      key_down = 1'b0;
      cycles(40);
      #2 rst = 1'b0;
      #1 check_reset_outputs("midrst");
      cycles(3);
      rst = 1'b1;
      cycles(250);
      rx_bytes.delete();
      rx_start.delete();
      exp_bytes.delete();

      // 6: long hold, one release bounce, then release
      kv0 = kv_cycles;
      k = int'($urandom_range(15, 0));
      press(k);
      push_msg(k);
      cycles(100*SCAN_DIV);
      key_down = 1'b0;
      cycles(SCAN_DIV);
      key_down = 1'b1;
      cycles(40);
      key_down = 1'b0;
      t = 0;
      while (col_out == ~(one << (k % 4)) && t < 60) begin @(negedge clk); t++; end
      exp_col = ~(one << ((k % 4 + 1) % 4));
      check_eq("s6_next_col", 32'(col_out), 32'(exp_col));
      check_eq("s6_kv_pulses", kv_cycles - kv0, 1);
      drain();
      compare_rx("s6");

      // randomized rounds of 1..3 keys, never enough to overflow
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(3, 1));
         for (int j = 0; j < n; j++) begin
            k = int'($urandom_range(15, 0));
            press(k);
            push_msg(k);
            release_key();
         end
         drain();
         compare_rx($sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_uart_tx.md
Name: keypad_uart_tx

Overview:
Parametrised matrix-keypad scanner with per-key debounce, key-code FIFO and 8N1 UART transmitter. Scans up to a 4x4 keypad one column at a time and debounces presses and releases. Each accepted key is queued, then sent as a framed UART message: PREFIX byte followed by the key's ASCII character. Sits between the keypad pins and the board UART TX pin; replaces single-key, non-buffered keypad handling.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz
BAUD, 9600, UART baud rate; BAUD_DIV = CLK_HZ/BAUD (integer floor; 2812 at defaults), must be >= 4
ROWS, 4, keypad rows, 1..4
COLS, 4, keypad columns, 1..4
SCAN_DIV, 27000, clock cycles each column is driven before its rows are sampled
DEBOUNCE_SCANS, 4, consecutive matching samples needed to accept a press or release, >= 1
FIFO_DEPTH, 8, key FIFO entries, power of two, >= 2
PREFIX, 8'h32, first byte of every message (ASCII "2")

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
row_in  in  ROWS  keypad rows, active-low (external pull-ups), asynchronous; two-flop synchronised internally
col_out  out  COLS  column drive, one-hot active-low
key_valid  out  1  one-cycle pulse when a debounced press is accepted
key_code  out  4  index of the last accepted key = row*4+col; held until the next accept
fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of queued keys
overflow  out  1  sticky; set when a key is dropped because the FIFO is full
tx_busy  out  1  high while a message is being sent
uart_tx  out  1  serial output, idle high

Behaviour:
- Reset (rst=0, asynchronous): col_out all ones; uart_tx=1; key_valid=0; key_code=0; fifo_count=0; overflow=0; tx_busy=0; all FSMs go to their first state; FIFO is emptied. Reset mid-frame stops the frame at once and uart_tx goes high.
- Scanner FSM: SCAN -> PRESS_DB -> HELD -> RELEASE_DB -> SCAN.
  - SCAN: drive column c (starting at 0) low for SCAN_DIV cycles, then sample the synchronised rows. If no row is low, advance c, wrapping from COLS-1 to 0. If any row is low, latch the lowest low row r and column c, then go to PRESS_DB.
  - PRESS_DB: keep column c driven and sample every SCAN_DIV cycles. Row r low counts one match; the first sample in SCAN counts as match 1. On reaching DEBOUNCE_SCANS matches, go to HELD. Row r high returns to SCAN at the next column.
  - HELD: on entry, pulse key_valid for 1 cycle, load key_code, and push into the FIFO in the same cycle. If the FIFO is full, drop the key and set overflow; key_valid still pulses. Stay until row r samples high, then go to RELEASE_DB.
  - RELEASE_DB: needs DEBOUNCE_SCANS consecutive high samples, then goes to SCAN at column (c+1) mod COLS. Any low sample returns to HELD with no new key_valid.
  - Other keys pressed while a key is held are ignored.
- FIFO: synchronous, first-word fall-through.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Push when full drops the new key; existing entries are kept.
- ASCII map, index 0..15 in order: "123A456B789C*0#D".
- UART FSM: IDLE -> START -> DATA -> STOP, repeated for each byte of a message.
  - IDLE: when fifo_count>0, pop the FIFO, set tx_busy=1 and start the PREFIX byte on the next cycle.
  - Each bit lasts exactly BAUD_DIV cycles, sent LSB first. Stop bit is 1 bit.
  - After the last byte's stop bit, return to IDLE and clear tx_busy.
  - There is no gap between messages when the FIFO still holds keys.

Optional Feature:
KPU_CRLF_EN:
- Defined: each message is PREFIX, ASCII, 8'h0D, 8'h0A (4 bytes).
- Undefined: each message is PREFIX, ASCII (2 bytes).
- Scanner and FIFO behaviour is identical in both cases.

Test Plan:
Small parameters for all scenarios: CLK_HZ=160, BAUD=10 (BAUD_DIV=16), SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
1. Hold row 1 low when column 2 is driven -> key_valid pulses once; key_code=6; uart_tx sends 0x32 then 0x36, each frame 160 cycles, LSB first; with KPU_CRLF_EN, 0x0D and 0x0A follow.
2. Row low for only one sample (bounce) -> no key_valid; scan resumes at the next column; fifo_count stays 0.
3. Press key 13, then key 0 while the first message is being sent -> messages "20" wait, then "21"; wait, correct order is "20" then "21" back-to-back with no idle gap; fifo_count peaks at 1. (Exact required result: two back-to-back messages, bytes 0x32 0x30 then 0x32 0x31.)
4. Six presses faster than the UART can drain them -> fifo_count saturates at 4; overflow=1; the first keys are transmitted in order and the last is dropped.
5. Pull rst low in the middle of the DATA state -> uart_tx=1 immediately; all outputs at reset values; overflow=0.
6. Hold a key for 100 scan periods, bounce the release once, then release -> exactly one key_valid; next scan starts at column (c+1) mod 4.
